// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states and architectural constants.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        CAPTURE = 2'd1,
        PRESENT = 2'd2,
        FAULT   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect input, decode handshake and status.
interface fetch_unit_if;
    import core_pkg::*;

    logic [XLEN-1:0] imem_address;
    logic [XLEN-1:0] imem_data_out;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            fetch_fault;
    logic [XLEN-1:0] fault_pc;
    logic [XLEN-1:0] fetch_count;

    modport master (
        output imem_address,
        input  imem_data_out,
        input  redirect_valid,
        input  redirect_target,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output fetch_fault,
        output fault_pc,
        output fetch_count
    );

    modport slave (
        input  imem_address,
        output imem_data_out,
        output redirect_valid,
        output redirect_target,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  fetch_fault,
        input  fault_pc,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, reads instruction memory, presents instructions over valid/ready,
// and applies redirects from execute. A misaligned redirect target locks the unit until reset.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset_n,
    fetch_unit_if.master fif
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
    logic            fault_reg, fault_next;
    logic [XLEN-1:0] fault_pc_reg, fault_pc_next;
    logic [XLEN-1:0] count_reg, count_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ISSUE;
            pc_reg       <= RESET_PC;
            instr_reg    <= INSTR_NOP;
            instr_pc_reg <= RESET_PC;
            fault_reg    <= 1'b0;
            fault_pc_reg <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
            count_reg    <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        count_next    = count_reg;

        case (state_reg)
            ISSUE:   state_next = CAPTURE;
            CAPTURE: begin
                instr_next    = fif.imem_data_out;
                instr_pc_next = pc_reg;
                state_next    = PRESENT;
            end
            PRESENT: begin
                if (fif.instr_ready) begin
                    pc_next    = pc_reg + PC_STEP;
                    count_next = count_reg + 32'd1;
                    state_next = ISSUE;
                end
            end
            default: state_next = FAULT;
        endcase

        // Redirect overrides the sequential path; the handshake count above still stands.
        if (state_reg != FAULT && fif.redirect_valid) begin
            instr_next    = instr_reg;
            instr_pc_next = instr_pc_reg;
            if (fif.redirect_target[1:0] == 2'b00) begin
                pc_next    = fif.redirect_target;
                state_next = ISSUE;
            end else begin
                pc_next       = pc_reg;
                state_next    = FAULT;
                fault_next    = 1'b1;
                fault_pc_next = fif.redirect_target;
            end
        end
    end

    // pc only moves on edges into ISSUE, so it doubles as the registered memory address.
    assign fif.imem_address = pc_reg;
    assign fif.instr_valid  = (state_reg == PRESENT);
    assign fif.instr        = instr_reg;
    assign fif.instr_pc     = instr_pc_reg;
    assign fif.fetch_fault  = fault_reg;
    assign fif.fault_pc     = fault_pc_reg;
    assign fif.fetch_count  = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected (instr, pc) pairs, a negedge monitor pops on handshakes.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] mem [0:255];
    txn_t sb_q[$];
    int checks = 0;
    int errors = 0;

    fetch_unit_if fif();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fif     (fif.master)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the address.
    always @(posedge clk) fif.imem_data_out <= mem[fif.imem_address[9:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] word, input logic [31:0] pc);
        txn_t t;
        t.word = word;
        t.pc   = pc;
        sb_q.push_back(t);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"},     fif.imem_address, 32'h0);
        chk({tag, "_instr"},    fif.instr, 32'h0000_0013);
        chk({tag, "_instr_pc"}, fif.instr_pc, 32'h0);
        chk({tag, "_valid"},    {31'b0, fif.instr_valid}, 32'h0);
        chk({tag, "_fault"},    {31'b0, fif.fetch_fault}, 32'h0);
        chk({tag, "_fault_pc"}, fif.fault_pc, 32'h0);
        chk({tag, "_count"},    fif.fetch_count, 32'h0);
    endtask

    always @(negedge clk) begin
        if (reset_n && fif.instr_valid && fif.instr_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake actual pc=%h instr=%h required none", fif.instr_pc, fif.instr);
            end else begin
                txn_t e;
                e = sb_q.pop_front();
                chk("sb_instr", fif.instr, e.word);
                chk("sb_pc", fif.instr_pc, e.pc);
                $display("txn pc=%h instr=%h count_before=%0d", fif.instr_pc, fif.instr, fif.fetch_count);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | (i * 4);
        mem[0] = 32'h0050_0093;
        fif.instr_ready     = 1'b0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_target = 32'h0;

        // Reset state
        repeat (2) step();
        chk_reset_values("rst");

        // Reset release, first fetch latency: cycle 0 now
        reset_n = 1'b1;
        fif.instr_ready = 1'b1;
        push(32'h0050_0093, 32'h0);
        chk("c0_addr", fif.imem_address, 32'h0);
        step();                                   // cycle 1
        chk("c1_valid", {31'b0, fif.instr_valid}, 32'h0);
        step();                                   // cycle 2
        chk("c2_valid", {31'b0, fif.instr_valid}, 32'h1);
        chk("c2_instr", fif.instr, 32'h0050_0093);
        chk("c2_pc", fif.instr_pc, 32'h0);
        step();                                   // cycle 3
        chk("c3_addr", fif.imem_address, 32'h4);
        chk("c3_count", fif.fetch_count, 32'h1);

        // Stall 5 cycles in PRESENT
        fif.instr_ready = 1'b0;
        push(32'hA500_0004, 32'h4);
        step();                                   // cycle 4
        step();                                   // cycle 5
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {31'b0, fif.instr_valid}, 32'h1);
            chk("stall_pc", fif.instr_pc, 32'h4);
            chk("stall_instr", fif.instr, 32'hA500_0004);
            chk("stall_addr", fif.imem_address, 32'h4);
            chk("stall_count", fif.fetch_count, 32'h1);
            step();
        end
        fif.instr_ready = 1'b1;                   // cycle 10
        step();                                   // cycle 11
        chk("post_stall_count", fif.fetch_count, 32'h2);
        chk("post_stall_addr", fif.imem_address, 32'h8);

        // Redirect to 0x40 during CAPTURE
        step();                                   // cycle 12 CAPTURE
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h40;
        push(32'hA500_0040, 32'h40);
        step();                                   // cycle 13
        fif.redirect_valid = 1'b0;
        chk("rd_addr", fif.imem_address, 32'h40);
        chk("rd_valid13", {31'b0, fif.instr_valid}, 32'h0);
        step();                                   // cycle 14
        chk("rd_valid14", {31'b0, fif.instr_valid}, 32'h0);
        step();                                   // cycle 15
        chk("rd_valid15", {31'b0, fif.instr_valid}, 32'h1);
        chk("rd_pc15", fif.instr_pc, 32'h40);
        step();                                   // cycle 16 ISSUE 0x44
        chk("rd_count", fif.fetch_count, 32'h3);

        // Redirect to 0x80 together with a handshake in PRESENT
        push(32'hA500_0044, 32'h44);
        step();                                   // cycle 17
        step();                                   // cycle 18 PRESENT
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h80;
        push(32'hA500_0080, 32'h80);
        step();                                   // cycle 19
        fif.redirect_valid = 1'b0;
        chk("rr_addr", fif.imem_address, 32'h80);
        chk("rr_count", fif.fetch_count, 32'h4);
        chk("rr_valid", {31'b0, fif.instr_valid}, 32'h0);
        step();                                   // cycle 20
        step();                                   // cycle 21
        chk("rr_pc21", fif.instr_pc, 32'h80);
        step();                                   // cycle 22 ISSUE 0x84
        chk("rr_count22", fif.fetch_count, 32'h5);

        // Misaligned redirect locks into FAULT
        fif.redirect_valid  = 1'b1;
        fif.redirect_target = 32'h42;
        step();                                   // cycle 23
        chk("flt_flag", {31'b0, fif.fetch_fault}, 32'h1);
        chk("flt_pc", fif.fault_pc, 32'h42);
        chk("flt_valid", {31'b0, fif.instr_valid}, 32'h0);
        fif.redirect_target = 32'h100;
        step();
        fif.redirect_valid = 1'b0;
        chk("flt_ignore_addr", fif.imem_address, 32'h84);
        chk("flt_ignore_fault_pc", fif.fault_pc, 32'h42);
        for (int k = 0; k < 4; k++) begin
            chk("flt_valid_hold", {31'b0, fif.instr_valid}, 32'h0);
            step();
        end
        reset_n = 1'b0;
        #1;
        chk("flt_clear", {31'b0, fif.fetch_fault}, 32'h0);
        chk("flt_clear_pc", fif.fault_pc, 32'h0);
        step();

        // Asynchronous reset mid-PRESENT
        reset_n = 1'b1;
        fif.instr_ready = 1'b0;
        step();
        step();
        chk("ar_valid_before", {31'b0, fif.instr_valid}, 32'h1);
        chk("ar_instr_before", fif.instr, 32'h0050_0093);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("async");
        step();

        // Restart from RESET_PC
        reset_n = 1'b1;
        fif.instr_ready = 1'b1;
        push(32'h0050_0093, 32'h0);
        push(32'hA500_0004, 32'h4);
        for (int k = 0; k < 6; k++) step();
        fif.instr_ready = 1'b0;
        step();
        step();
        chk("restart_count", fif.fetch_count, 32'h2);
        chk("restart_addr", fif.imem_address, 32'h8);
        chk("sb_drained", sb_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
